pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the KGP_RISC fetch stage. It holds the current instruction address and computes the next one each cycle: sequential step, PC-relative branch, absolute jump, call/return through a small return-address stack (RAS), stall and halt/resume. It replaces the purely combinational address incrementer and feeds the instruction-memory address port.

---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: step, branch, jump, call/return via circular RAS, halt/resume.
// Latency 1 cycle from controls to pc; stall freezes all state, there is no other backpressure.
module pc_sequencer #(
    parameter int ADDR_W    = 13,
    parameter int STEP      = 1,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_off,
    input  logic              jmp,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              halted,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_VEC);
    localparam logic [PW:0]       CNT_MAX = (PW+1)'(RAS_DEPTH);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t            state, state_nxt;
    logic [PW:0]       ras_cnt;
    logic [PW-1:0]     ras_wp;
    logic [PW-1:0]     ras_top_idx;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic              do_push, do_pop, set_ovf, set_unf;

    assign link_addr   = pc + STEP_V;
    assign ras_top_idx = ras_wp - PW'(1);
    assign ras_empty   = (ras_cnt == '0);
    assign ras_full    = (ras_cnt == CNT_MAX);
    assign halted      = (state == S_HALT);

    always_comb begin
        state_nxt = state;
        next_pc   = pc;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        case (state)
            S_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_nxt = S_HALT;
                    end else if (ret) begin
                        if (!ras_empty) begin
                            next_pc = ras_mem[ras_top_idx];
                            do_pop  = 1'b1;
                        end else begin
                            next_pc = link_addr;
                            set_unf = 1'b1;
                        end
                    end else if (call) begin
                        next_pc = jmp_addr;
                        do_push = 1'b1;
                        set_ovf = ras_full;
                    end else if (jmp) begin
                        next_pc = jmp_addr;
                    end else if (br_taken) begin
                        // Offset already spans ADDR_W, so the modular add is the sign-extended add.
                        next_pc = pc + br_off;
                    end else begin
                        next_pc = link_addr;
                    end
                end
            end
            S_HALT: begin
                if (!stall && resume)
                    state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RUN;
            pc      <= RESET_V;
            ras_cnt <= '0;
            ras_wp  <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= next_pc;
            if (do_push) begin
                ras_wp <= ras_wp + PW'(1);
                // When full the write lands on the oldest slot, so the count saturates.
                if (!ras_full)
                    ras_cnt <= ras_cnt + (PW+1)'(1);
            end else if (do_pop) begin
                ras_wp  <= ras_top_idx;
                ras_cnt <= ras_cnt - (PW+1)'(1);
            end
            if (set_ovf) ras_ovf <= 1'b1;
            if (set_unf) ras_unf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst)
            ras_mem[ras_wp] <= link_addr;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-scenario tasks, expected PCs queued at drive time and popped after each edge.
module tb_pc_sequencer;

    localparam int AW = 13;

    localparam logic [6:0] C_NONE  = 7'd0;
    localparam logic [6:0] C_BR    = 7'd1;
    localparam logic [6:0] C_JMP   = 7'd2;
    localparam logic [6:0] C_CALL  = 7'd4;
    localparam logic [6:0] C_RET   = 7'd8;
    localparam logic [6:0] C_RES   = 7'd16;
    localparam logic [6:0] C_HALT  = 7'd32;
    localparam logic [6:0] C_STALL = 7'd64;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, halt, resume, br_taken, jmp, call, ret;
    logic [AW-1:0] br_off, jmp_addr;
    logic [AW-1:0] pc, next_pc, link_addr;
    logic          halted, ras_empty, ras_full, ras_ovf, ras_unf;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW-1:0] exp_q [$];

    pc_sequencer #(.ADDR_W(AW), .STEP(1), .RESET_VEC(0), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
        .br_taken(br_taken), .br_off(br_off), .jmp(jmp), .call(call), .ret(ret),
        .jmp_addr(jmp_addr), .pc(pc), .next_pc(next_pc), .link_addr(link_addr),
        .halted(halted), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [AW-1:0] a,
                         input logic [AW-1:0] off, input logic [AW-1:0] e);
        {stall, halt, resume, ret, call, jmp, br_taken} = ctl;
        jmp_addr = a;
        br_off   = off;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        logic [AW-1:0] e;
        rst = 1'b1;
        {stall, halt, resume, ret, call, jmp, br_taken} = C_NONE;
        jmp_addr = '0;
        br_off   = '0;
        #1;
        n_checks++;
        if ({halted, ras_empty, ras_full, ras_ovf, ras_unf} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=01000", {halted, ras_empty, ras_full, ras_ovf, ras_unf});
        end
        tick();
        tick();
        exp_q.push_back('0);
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e) begin n_fail++; $display("FAIL reset_pc got=%0d exp=%0d", pc, e); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [6:0]    ctl [7] = '{C_NONE, C_NONE, C_NONE, C_NONE, C_NONE, C_JMP, C_NONE};
        logic [AW-1:0] adr [7] = '{13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd8191, 13'd0};
        logic [AW-1:0] ex  [7] = '{13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd8191, 13'd0};
        logic [AW-1:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(ctl[i], adr[i], '0, ex[i]);
            n_checks++;
            if (next_pc !== ex[i]) begin n_fail++; $display("FAIL seq_next_pc step=%0d got=%0d exp=%0d", i, next_pc, ex[i]); end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (pc !== e) begin n_fail++; $display("FAIL seq_pc step=%0d got=%0d exp=%0d", i, pc, e); end
        end
    endtask

    task automatic test_branch();
        logic [6:0]    ctl [4] = '{C_JMP, C_BR, C_JMP, C_JMP | C_BR};
        logic [AW-1:0] adr [4] = '{13'd10, 13'd0, 13'd10, 13'd100};
        logic [AW-1:0] off [4] = '{13'd0, 13'h1FFC, 13'd0, 13'h1FFC};
        logic [AW-1:0] ex  [4] = '{13'd10, 13'd6, 13'd10, 13'd100};
        logic [AW-1:0] e;
        for (int i = 0; i < 4; i++) begin
            drive(ctl[i], adr[i], off[i], ex[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (pc !== e) begin n_fail++; $display("FAIL branch_pc step=%0d got=%0d exp=%0d", i, pc, e); end
        end
    endtask

    task automatic test_call_ret();
        logic [6:0]    ctl [5] = '{C_JMP, C_CALL, C_CALL, C_RET, C_RET};
        logic [AW-1:0] adr [5] = '{13'd20, 13'd50, 13'd80, 13'd0, 13'd0};
        logic [AW-1:0] ex  [5] = '{13'd20, 13'd50, 13'd80, 13'd51, 13'd21};
        logic [AW-1:0] e;
        for (int i = 0; i < 5; i++) begin
            drive(ctl[i], adr[i], '0, ex[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (pc !== e) begin n_fail++; $display("FAIL call_ret_pc step=%0d got=%0d exp=%0d", i, pc, e); end
        end
        n_checks++;
        if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL call_ret_empty got=%b exp=1", ras_empty); end
    endtask

    task automatic test_ras_overflow();
        logic [6:0]    ctl [10] = '{C_CALL, C_CALL, C_CALL, C_CALL, C_CALL,
                                    C_RET, C_RET, C_RET, C_RET, C_RET};
        logic [AW-1:0] adr [10] = '{13'd100, 13'd200, 13'd300, 13'd400, 13'd500,
                                    13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
        logic [AW-1:0] ex  [10] = '{13'd100, 13'd200, 13'd300, 13'd400, 13'd500,
                                    13'd401, 13'd301, 13'd201, 13'd101, 13'd102};
        logic [AW-1:0] e;
        for (int i = 0; i < 10; i++) begin
            drive(ctl[i], adr[i], '0, ex[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (pc !== e) begin n_fail++; $display("FAIL ovf_pc step=%0d got=%0d exp=%0d", i, pc, e); end
            if (i == 4) begin
                n_checks++;
                if ({ras_full, ras_ovf, ras_unf} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL ovf_flags got=%b exp=110", {ras_full, ras_ovf, ras_unf});
                end
            end
            if (i == 8) begin
                n_checks++;
                if ({ras_empty, ras_unf} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL drained_flags got=%b exp=10", {ras_empty, ras_unf});
                end
            end
        end
        n_checks++;
        if ({ras_empty, ras_ovf, ras_unf} !== 3'b111) begin
            n_fail++;
            $display("FAIL unf_flags got=%b exp=111", {ras_empty, ras_ovf, ras_unf});
        end
    endtask

    task automatic test_halt();
        logic [6:0]    ctl [7] = '{C_JMP, C_HALT, C_JMP, C_JMP, C_JMP, C_RES, C_NONE};
        logic [AW-1:0] adr [7] = '{13'd30, 13'd0, 13'd999, 13'd999, 13'd999, 13'd0, 13'd0};
        logic [AW-1:0] ex  [7] = '{13'd30, 13'd30, 13'd30, 13'd30, 13'd30, 13'd30, 13'd31};
        logic          hx  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [AW-1:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(ctl[i], adr[i], '0, ex[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (pc !== e || halted !== hx[i]) begin
                n_fail++;
                $display("FAIL halt step=%0d got pc=%0d halted=%b exp pc=%0d halted=%b", i, pc, halted, e, hx[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [6:0]    ctl [3] = '{C_STALL | C_CALL, C_STALL | C_CALL, C_NONE};
        logic [AW-1:0] ex  [3] = '{13'd31, 13'd31, 13'd32};
        logic [AW-1:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(ctl[i], 13'd200, '0, ex[i]);
            n_checks++;
            if (next_pc !== ex[i]) begin n_fail++; $display("FAIL stall_next_pc step=%0d got=%0d exp=%0d", i, next_pc, ex[i]); end
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (pc !== e || ras_empty !== 1'b1) begin
                n_fail++;
                $display("FAIL stall step=%0d got pc=%0d empty=%b exp pc=%0d empty=1", i, pc, ras_empty, e);
            end
        end
    endtask

    task automatic test_rst_midcycle();
        logic [AW-1:0] e;
        drive(C_HALT, 13'd77, '0, 13'd0);
        #2;
        rst = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e || {halted, ras_ovf, ras_unf, ras_empty} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_async got pc=%0d flags=%b exp pc=%0d flags=0001",
                     pc, {halted, ras_ovf, ras_unf, ras_empty}, e);
        end
        tick();
        rst = 1'b0;
        drive(C_NONE, '0, '0, 13'd1);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (pc !== e || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release got pc=%0d halted=%b exp pc=%0d halted=0", pc, halted, e);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_call_ret();
        test_ras_overflow();
        test_halt();
        test_stall();
        test_rst_midcycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
